// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the register file write port (A: ALU, B: load), 1-cycle write latency.
// No back-pressure from the RF: one grant per cycle; the loser holds its request until granted.
module reg_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              byp_hit1,
  output logic              byp_hit2,
  output logic [DATA_W-1:0] byp_data
);

  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  // Set when B holds the most recent grant, so A wins the next conflict.
  logic              last_b_q, last_b_d;
  logic              a_hs, b_hs;

  always_comb begin
    a_ready = !rst && a_valid && (!b_valid || last_b_q);
    b_ready = !rst && b_valid && (!a_valid || !last_b_q);
    a_hs    = a_valid && a_ready;
    b_hs    = b_valid && b_ready;
  end

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    last_b_d   = last_b_q;
    if (a_hs) begin
      rf_we_d    = (a_addr != '0);
      rf_waddr_d = a_addr;
      rf_wdata_d = a_data;
      last_b_d   = 1'b0;
    end else if (b_hs) begin
      rf_we_d    = (b_addr != '0);
      rf_waddr_d = b_addr;
      rf_wdata_d = b_data;
      last_b_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      last_b_q   <= 1'b1;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      last_b_q   <= last_b_d;
    end
  end

  // rf_we is never set for register 0, so reads of r0 cannot hit.
  always_comb begin
    rf_we    = rf_we_q;
    rf_waddr = rf_waddr_q;
    rf_wdata = rf_wdata_q;
    byp_hit1 = rf_we_q && (rd_addr1 == rf_waddr_q);
    byp_hit2 = rf_we_q && (rd_addr2 == rf_waddr_q);
    byp_data = rf_wdata_q;
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: reset, contention, r0 drop, same-address, bypass, idle hold.
module tb_reg_write_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              a_valid, b_valid;
  logic              a_ready, b_ready;
  logic [ADDR_W-1:0] a_addr, b_addr, rd_addr1, rd_addr2;
  logic [DATA_W-1:0] a_data, b_data;
  logic              rf_we, byp_hit1, byp_hit2;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata, byp_data;

  int vectors = 0;
  int miscompares = 0;

  logic [DATA_W-1:0] regs [32];

  reg_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2), .byp_data(byp_data)
  );

  always #5 clk = ~clk;

  // Register file model fed by the write port.
  always @(posedge clk) if (rf_we) regs[rf_waddr] <= rf_wdata;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; a_valid = 1'b1; a_addr = 5'd2; a_data = 32'd25;
    b_valid = 1'b0; b_addr = '0; b_data = '0; rd_addr1 = '0; rd_addr2 = '0;
    #2;
    vectors++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_state: we=%0b waddr=%0d wdata=%0d, expected 0/0/0", rf_we, rf_waddr, rf_wdata);
    end
    vectors++;
    if (a_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: a_ready=%0b, expected 0", a_ready);
    end
    tick;
    rst = 1'b0;
    #1;
    vectors++;
    if (a_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL release_ready: a_ready=%0b, expected 1", a_ready);
    end
    tick;
    vectors++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd2 || rf_wdata !== 32'd25) begin
      miscompares++;
      $display("FAIL first_write: we=%0b waddr=%0d wdata=%0d, expected 1/2/25", rf_we, rf_waddr, rf_wdata);
    end
    // Mid-cycle async reset while a write is in flight.
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (rf_we !== 1'b0 || a_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: we=%0b a_ready=%0b, expected 0/0", rf_we, a_ready);
    end
    tick;
    vectors++;
    if (rf_we !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: we=%0b, expected 0", rf_we);
    end
    rst = 1'b0;
    tick;
    vectors++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd2 || rf_wdata !== 32'd25) begin
      miscompares++;
      $display("FAIL post_reset_write: we=%0b waddr=%0d wdata=%0d, expected 1/2/25", rf_we, rf_waddr, rf_wdata);
    end
    a_valid = 1'b0;
    tick;
  endtask

  task automatic test_contention;
    // Reset pulse restores the B-last pointer so A wins first.
    rst = 1'b1; #1 rst = 1'b0;
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'd10;
    b_valid = 1'b1; b_addr = 5'd4; b_data = 32'd20;
    #1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (a_ready !== (i % 2 == 0) || b_ready !== (i % 2 == 1)) begin
        miscompares++;
        $display("FAIL contention_ready[%0d]: a_ready=%0b b_ready=%0b, expected %0b/%0b",
                 i, a_ready, b_ready, (i % 2 == 0), (i % 2 == 1));
      end
      tick;
      vectors++;
      if (rf_we !== 1'b1 || rf_waddr !== ((i % 2 == 0) ? 5'd3 : 5'd4) ||
          rf_wdata !== ((i % 2 == 0) ? 32'd10 : 32'd20)) begin
        miscompares++;
        $display("FAIL contention_write[%0d]: we=%0b waddr=%0d wdata=%0d, expected 1/%0d/%0d",
                 i, rf_we, rf_waddr, rf_wdata, (i % 2 == 0) ? 3 : 4, (i % 2 == 0) ? 10 : 20);
      end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    tick;
  endtask

  task automatic test_r0_drop;
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'd99; rd_addr1 = 5'd0;
    #1;
    vectors++;
    if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL r0_ready: b_ready=%0b a_ready=%0b, expected 1/0", b_ready, a_ready);
    end
    tick;
    vectors++;
    if (rf_we !== 1'b0 || byp_hit1 !== 1'b0) begin
      miscompares++;
      $display("FAIL r0_dropped: we=%0b byp_hit1=%0b, expected 0/0", rf_we, byp_hit1);
    end
    b_addr = 5'd5;
    tick;
    vectors++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'd99) begin
      miscompares++;
      $display("FAIL r5_write: we=%0b waddr=%0d wdata=%0d, expected 1/5/99", rf_we, rf_waddr, rf_wdata);
    end
    b_valid = 1'b0;
    tick;
  endtask

  task automatic test_same_addr;
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'd1;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'd2;
    #1;
    vectors++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL same_first_grant: a_ready=%0b b_ready=%0b, expected 1/0", a_ready, b_ready);
    end
    tick;
    a_valid = 1'b0;
    vectors++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'd1) begin
      miscompares++;
      $display("FAIL same_write1: we=%0b waddr=%0d wdata=%0d, expected 1/7/1", rf_we, rf_waddr, rf_wdata);
    end
    tick;
    b_valid = 1'b0;
    vectors++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'd2) begin
      miscompares++;
      $display("FAIL same_write2: we=%0b waddr=%0d wdata=%0d, expected 1/7/2", rf_we, rf_waddr, rf_wdata);
    end
    tick;
    vectors++;
    if (regs[7] !== 32'd2) begin
      miscompares++;
      $display("FAIL same_final: r7=%0d, expected 2", regs[7]);
    end
  endtask

  task automatic test_bypass;
    a_valid = 1'b1; a_addr = 5'd2; a_data = 32'd25; rd_addr1 = 5'd2; rd_addr2 = 5'd1;
    tick;
    a_valid = 1'b0;
    #1;
    vectors++;
    if (byp_hit1 !== 1'b1 || byp_hit2 !== 1'b0 || byp_data !== 32'd25) begin
      miscompares++;
      $display("FAIL bypass_hit: hit1=%0b hit2=%0b data=%0d, expected 1/0/25", byp_hit1, byp_hit2, byp_data);
    end
    tick;
    vectors++;
    if (byp_hit1 !== 1'b0 || byp_hit2 !== 1'b0) begin
      miscompares++;
      $display("FAIL bypass_idle: hit1=%0b hit2=%0b, expected 0/0", byp_hit1, byp_hit2);
    end
  endtask

  task automatic test_idle_hold;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (rf_we !== 1'b0 || rf_waddr !== 5'd2 || a_ready !== 1'b0 || b_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL idle[%0d]: we=%0b waddr=%0d a_ready=%0b b_ready=%0b, expected 0/2/0/0",
                 i, rf_we, rf_waddr, a_ready, b_ready);
      end
      tick;
    end
    // A won last (bypass test), so B takes this conflict.
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'd10;
    b_valid = 1'b1; b_addr = 5'd4; b_data = 32'd20;
    #1;
    vectors++;
    if (a_ready !== 1'b0 || b_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_pointer: a_ready=%0b b_ready=%0b, expected 0/1", a_ready, b_ready);
    end
    tick;
    a_valid = 1'b0; b_valid = 1'b0;
    vectors++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'd20) begin
      miscompares++;
      $display("FAIL idle_grant: we=%0b waddr=%0d wdata=%0d, expected 1/4/20", rf_we, rf_waddr, rf_wdata);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_contention;
    test_r0_drop;
    test_same_addr;
    test_bypass;
    test_idle_hold;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
